// File: rtl/jogo_pkg.sv
// Shared state codes and control-word type for the memory-game control unit.
package jogo_pkg;

  localparam int ESTADO_W = 4;

  localparam logic [ESTADO_W-1:0] C_INICIAL       = 4'h0;
  localparam logic [ESTADO_W-1:0] C_PREPARA       = 4'h1;
  localparam logic [ESTADO_W-1:0] C_INICIA_RODADA = 4'h2;
  localparam logic [ESTADO_W-1:0] C_EXIBE         = 4'h3;
  localparam logic [ESTADO_W-1:0] C_PROX_EXIBE    = 4'h4;
  localparam logic [ESTADO_W-1:0] C_ESPERA        = 4'h5;
  localparam logic [ESTADO_W-1:0] C_REGISTRA      = 4'h6;
  localparam logic [ESTADO_W-1:0] C_COMPARA       = 4'h7;
  localparam logic [ESTADO_W-1:0] C_PROX_JOGADA   = 4'h8;
  localparam logic [ESTADO_W-1:0] C_ESPERA_NOVA   = 4'h9;
  localparam logic [ESTADO_W-1:0] C_ESCREVE_NOVA  = 4'hA;
  localparam logic [ESTADO_W-1:0] C_PROX_RODADA   = 4'hB;
  localparam logic [ESTADO_W-1:0] C_GANHOU        = 4'hC;
  localparam logic [ESTADO_W-1:0] C_PERDEU        = 4'hD;
  localparam logic [ESTADO_W-1:0] C_TIMEOUT       = 4'hE;

  typedef enum logic [ESTADO_W-1:0] {
    INICIAL       = C_INICIAL,
    PREPARA       = C_PREPARA,
    INICIA_RODADA = C_INICIA_RODADA,
    EXIBE         = C_EXIBE,
    PROX_EXIBE    = C_PROX_EXIBE,
    ESPERA        = C_ESPERA,
    REGISTRA      = C_REGISTRA,
    COMPARA       = C_COMPARA,
    PROX_JOGADA   = C_PROX_JOGADA,
    ESPERA_NOVA   = C_ESPERA_NOVA,
    ESCREVE_NOVA  = C_ESCREVE_NOVA,
    PROX_RODADA   = C_PROX_RODADA,
    GANHOU        = C_GANHOU,
    PERDEU        = C_PERDEU,
    TIMEOUT       = C_TIMEOUT
  } estado_t;

  typedef struct packed {
    logic zera_e;
    logic conta_e;
    logic zera_r;
    logic conta_r;
    logic zera_t;
    logic conta_t;
    logic registra_j;
    logic escreve_m;
    logic exibe;
    logic pronto;
    logic ganhou;
    logic perdeu;
  } saidas_t;

endpackage

// File: rtl/unidade_controle_jogo_if.sv
// Control/status bundle between the game control unit and its datapath.
interface unidade_controle_jogo_if;
  logic iniciar, jogada, igual, enderecoIgualRodada, fimRodadas, fimExibe, timeout;
  logic zeraE, contaE, zeraR, contaR, zeraT, contaT;
  logic registraJ, escreveM, exibe, pronto, ganhou, perdeu;

  modport slave (
    input  iniciar, jogada, igual, enderecoIgualRodada, fimRodadas, fimExibe, timeout,
    output zeraE, contaE, zeraR, contaR, zeraT, contaT,
           registraJ, escreveM, exibe, pronto, ganhou, perdeu
  );

  modport master (
    output iniciar, jogada, igual, enderecoIgualRodada, fimRodadas, fimExibe, timeout,
    input  zeraE, contaE, zeraR, contaR, zeraT, contaT,
           registraJ, escreveM, exibe, pronto, ganhou, perdeu
  );
endinterface

// File: rtl/jogo_decodifica_saidas.sv
// Combinational state -> control-word decoder; entrada marks the first cycle
// of ESPERA (after EXIBE) or ESPERA_NOVA.
module jogo_decodifica_saidas
  import jogo_pkg::*;
(
  input  estado_t estado,
  input  logic    entrada,
  output saidas_t saidas
);

  always_comb begin
    saidas = '0;
    case (estado)
      PREPARA: begin
        saidas.zera_r = 1'b1;
        saidas.zera_e = 1'b1;
        saidas.zera_t = 1'b1;
      end
      INICIA_RODADA: begin
        saidas.zera_e = 1'b1;
        saidas.zera_t = 1'b1;
      end
      EXIBE: begin
        saidas.exibe   = 1'b1;
        saidas.conta_t = 1'b1;
      end
      PROX_EXIBE: begin
        saidas.conta_e = 1'b1;
        saidas.zera_t  = 1'b1;
      end
      ESPERA: begin
        saidas.conta_t = 1'b1;
        saidas.zera_e  = entrada;
      end
      REGISTRA: begin
        saidas.registra_j = 1'b1;
        saidas.zera_t     = 1'b1;
      end
      PROX_JOGADA: saidas.conta_e = 1'b1;
      // first cycle steps the address past the round, then the timer runs
      ESPERA_NOVA: begin
        saidas.conta_e = entrada;
        saidas.conta_t = ~entrada;
      end
      ESCREVE_NOVA: begin
        saidas.registra_j = 1'b1;
        saidas.escreve_m  = 1'b1;
      end
      PROX_RODADA: begin
        saidas.conta_r = 1'b1;
        saidas.zera_e  = 1'b1;
        saidas.zera_t  = 1'b1;
      end
      GANHOU: begin
        saidas.pronto = 1'b1;
        saidas.ganhou = 1'b1;
      end
      PERDEU, TIMEOUT: begin
        saidas.pronto = 1'b1;
        saidas.perdeu = 1'b1;
      end
      default: saidas = '0;
    endcase
  end

endmodule

// File: rtl/unidade_controle_jogo.sv
// Moore control unit for the memory game. JOGO_TIMEOUT_EN enables the play
// timeout in ESPERA/ESPERA_NOVA; without it the timeout input is ignored.
//
// state          | meaning
// INICIAL      0 | idle, waiting for iniciar
// PREPARA      1 | clear round, address and timer
// INICIA_RODADA 2| clear address and timer for the round
// EXIBE        3 | show word at address until display timer ends
// PROX_EXIBE   4 | step address, restart timer
// ESPERA       5 | wait for a repeat play (address cleared on entry)
// REGISTRA     6 | latch play
// COMPARA      7 | check play against memory
// PROX_JOGADA  8 | step address to next repeat
// ESPERA_NOVA  9 | wait for the new play (address stepped on entry)
// ESCREVE_NOVA A | latch and store the new play
// PROX_RODADA  B | advance round
// GANHOU       C | won
// PERDEU       D | wrong play
// TIMEOUT      E | play timer expired
module unidade_controle_jogo #(
  parameter int ESTADO_W = jogo_pkg::ESTADO_W
) (
  input  logic                    clock,
  input  logic                    reset,
  unidade_controle_jogo_if.slave  bus,
  output logic [ESTADO_W-1:0]     db_estado
);
  import jogo_pkg::*;

  estado_t estado_q, estado_d;
  logic    entrada_q, entrada_d;
  saidas_t saidas_q, saidas_d;
  logic    timeout_ok;

`ifdef JOGO_TIMEOUT_EN
  assign timeout_ok = bus.timeout;
`else
  logic unused_timeout;
  assign unused_timeout = bus.timeout;
  assign timeout_ok     = 1'b0;
`endif

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      INICIAL:       if (bus.iniciar) estado_d = PREPARA;
      PREPARA:       estado_d = INICIA_RODADA;
      INICIA_RODADA: estado_d = EXIBE;
      EXIBE:         if (bus.fimExibe)
                       estado_d = bus.enderecoIgualRodada ? ESPERA : PROX_EXIBE;
      PROX_EXIBE:    estado_d = EXIBE;
      ESPERA:        if (bus.jogada)    estado_d = REGISTRA;
                     else if (timeout_ok) estado_d = TIMEOUT;
      REGISTRA:      estado_d = COMPARA;
      COMPARA:       if (!bus.igual)                    estado_d = PERDEU;
                     else if (!bus.enderecoIgualRodada) estado_d = PROX_JOGADA;
                     else if (bus.fimRodadas)           estado_d = GANHOU;
                     else                               estado_d = ESPERA_NOVA;
      PROX_JOGADA:   estado_d = ESPERA;
      ESPERA_NOVA:   if (bus.jogada)    estado_d = ESCREVE_NOVA;
                     else if (timeout_ok) estado_d = TIMEOUT;
      ESCREVE_NOVA:  estado_d = PROX_RODADA;
      PROX_RODADA:   estado_d = INICIA_RODADA;
      GANHOU, PERDEU, TIMEOUT: if (bus.iniciar) estado_d = PREPARA;
      default:       estado_d = INICIAL;
    endcase
  end

  // ESPERA re-entered from PROX_JOGADA must keep its address, so only these two arcs flag entry
  assign entrada_d = (estado_q == EXIBE   && estado_d == ESPERA) ||
                     (estado_q == COMPARA && estado_d == ESPERA_NOVA);

  jogo_decodifica_saidas u_decodifica (
    .estado  (estado_q),
    .entrada (entrada_q),
    .saidas  (saidas_d)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q  <= INICIAL;
      entrada_q <= 1'b0;
      saidas_q  <= '0;
    end else begin
      estado_q  <= estado_d;
      entrada_q <= entrada_d;
      saidas_q  <= saidas_d;
    end
  end

  assign bus.zeraE     = saidas_q.zera_e;
  assign bus.contaE    = saidas_q.conta_e;
  assign bus.zeraR     = saidas_q.zera_r;
  assign bus.contaR    = saidas_q.conta_r;
  assign bus.zeraT     = saidas_q.zera_t;
  assign bus.contaT    = saidas_q.conta_t;
  assign bus.registraJ = saidas_q.registra_j;
  assign bus.escreveM  = saidas_q.escreve_m;
  assign bus.exibe     = saidas_q.exibe;
  assign bus.pronto    = saidas_q.pronto;
  assign bus.ganhou    = saidas_q.ganhou;
  assign bus.perdeu    = saidas_q.perdeu;
  assign db_estado     = ESTADO_W'(estado_q);

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Bench for unidade_controle_jogo: a reference model checked every cycle plus directed literals.
module tb_unidade_controle_jogo;
  import jogo_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] db_estado;
  int         checks = 0;
  int         fails  = 0;

  unidade_controle_jogo_if bus();

  unidade_controle_jogo dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  // control word bit positions
  localparam logic [11:0] ZE = 12'h800, CE = 12'h400, ZR = 12'h200, CR = 12'h100,
                          ZT = 12'h080, CT = 12'h040, RJ = 12'h020, EM = 12'h010,
                          EX = 12'h008, PR = 12'h004, GA = 12'h002, PE = 12'h001;

  logic [11:0] act;
  assign act = {bus.zeraE, bus.contaE, bus.zeraR, bus.contaR, bus.zeraT, bus.contaT,
                bus.registraJ, bus.escreveM, bus.exibe, bus.pronto, bus.ganhou, bus.perdeu};

  // ---------------- reference model ----------------
  logic [3:0]  m_st;
  logic        m_first;
  logic [11:0] m_out;
  logic        m_to;

`ifdef JOGO_TIMEOUT_EN
  assign m_to = bus.timeout;
`else
  assign m_to = 1'b0;
`endif

  function automatic logic [11:0] m_dec(input logic [3:0] s, input logic first);
    logic [11:0] tbl [16];
    tbl = '{12'h000, ZR|ZE|ZT, ZE|ZT, EX|CT, CE|ZT, CT, RJ|ZT, 12'h000,
            CE, CT, RJ|EM, CR|ZE|ZT, PR|GA, PR|PE, PR|PE, 12'h000};
    if (first && s == 4'h5) return CT | ZE;
    if (first && s == 4'h9) return CE;
    return tbl[s];
  endfunction

  function automatic logic [3:0] m_next(input logic [3:0] s);
    case (s)
      4'h0:    return bus.iniciar ? 4'h1 : 4'h0;
      4'h3:    return !bus.fimExibe ? 4'h3 : (bus.enderecoIgualRodada ? 4'h5 : 4'h4);
      4'h4:    return 4'h3;
      4'h5:    return bus.jogada ? 4'h6 : (m_to ? 4'hE : 4'h5);
      4'h7:    return !bus.igual ? 4'hD : !bus.enderecoIgualRodada ? 4'h8 :
                      bus.fimRodadas ? 4'hC : 4'h9;
      4'h8:    return 4'h5;
      4'h9:    return bus.jogada ? 4'hA : (m_to ? 4'hE : 4'h9);
      4'hB:    return 4'h2;
      4'hC, 4'hD, 4'hE: return bus.iniciar ? 4'h1 : s;
      4'hF:    return 4'h0;
      default: return s + 4'h1;  // 1->2, 2->3, 6->7, A->B
    endcase
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_st <= 4'h0; m_first <= 1'b0; m_out <= 12'h000;
    end else begin
      m_out   <= m_dec(m_st, m_first);
      m_st    <= m_next(m_st);
      m_first <= (m_st == 4'h3 && m_next(m_st) == 4'h5) ||
                 (m_st == 4'h7 && m_next(m_st) == 4'h9);
    end
  end

  always @(negedge clock) begin
    checks++;
    if (db_estado !== m_st) begin
      fails++;
      $display("FAIL cycle_state: db_estado=%h model=%h at %0t", db_estado, m_st, $time);
    end
    checks++;
    if (act !== m_out) begin
      fails++;
      $display("FAIL cycle_outputs: got=%h model=%h state=%h at %0t", act, m_out, m_st, $time);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(negedge clock); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic pulse_jogada();
    bus.jogada = 1'b1; tick(); bus.jogada = 1'b0;
  endtask

  task automatic to_espera_from_prepara();
    tick(); chk("prep_to_2", db_estado, 4'h2);
    tick(); chk("prep_to_3", db_estado, 4'h3);
    bus.fimExibe = 1'b1; bus.enderecoIgualRodada = 1'b1;
    tick(); chk("exibe_to_espera", db_estado, 4'h5);
    bus.fimExibe = 1'b0;
  endtask

  int n_em, n_cr;

  initial begin
    reset = 1'b0;
    bus.iniciar = 0; bus.jogada = 0; bus.igual = 0; bus.enderecoIgualRodada = 0;
    bus.fimRodadas = 0; bus.fimExibe = 0; bus.timeout = 0;
    repeat (3) tick();
    chk("reset_state", db_estado, 4'h0);
    chk("reset_outputs", act, 12'h000);
    reset = 1'b1;
    repeat (2) tick();
    chk("idle_state", db_estado, 4'h0);

    // start; iniciar held high must not disturb non-terminal states
    bus.iniciar = 1'b1;
    tick(); chk("start_1", db_estado, 4'h1);
    tick(); chk("start_2", db_estado, 4'h2);
    tick(); chk("start_3", db_estado, 4'h3);
    tick(); chk("exibe_on", bus.exibe, 1'b1);
    chk("status_quiet", {bus.pronto, bus.ganhou, bus.perdeu}, 3'b000);
    bus.iniciar = 1'b0;

    // round 0
    bus.fimExibe = 1'b1; bus.enderecoIgualRodada = 1'b1;
    tick(); chk("r0_espera", db_estado, 4'h5);
    bus.fimExibe = 1'b0;
    tick(); chk("r0_espera_zerae", bus.zeraE, 1'b1);
    tick(); chk("r0_espera_zerae_once", bus.zeraE, 1'b0);
    bus.igual = 1'b1;
    pulse_jogada(); chk("r0_registra", db_estado, 4'h6);
    tick(); chk("r0_compara", db_estado, 4'h7);
    tick(); chk("r0_espera_nova", db_estado, 4'h9);
    tick(); chk("r0_nova_contae", bus.contaE, 1'b1);
    pulse_jogada(); chk("r0_escreve", db_estado, 4'hA);
    n_em = 0; n_cr = 0;
    for (int i = 0; i < 5; i++) begin
      n_em += int'(bus.escreveM); n_cr += int'(bus.contaR);
      if (i < 4) tick();
    end
    chk("r0_escrevem_once", n_em, 1);
    chk("r0_contar_once", n_cr, 1);
    chk("r0_back_exibe", db_estado, 4'h3);

    // timeout while waiting for a repeat
    bus.fimExibe = 1'b1; bus.enderecoIgualRodada = 1'b1;
    tick(); chk("to_espera", db_estado, 4'h5);
    bus.fimExibe = 1'b0; bus.timeout = 1'b1;
    repeat (3) tick();
`ifdef JOGO_TIMEOUT_EN
    chk("to_state", db_estado, 4'hE);
    chk("to_perdeu", {bus.pronto, bus.perdeu}, 2'b11);
    bus.timeout = 1'b0;
    bus.iniciar = 1'b1; tick(); bus.iniciar = 1'b0;
    chk("to_restart", db_estado, 4'h1);
    to_espera_from_prepara();
`else
    chk("to_ignored", db_estado, 4'h5);
    chk("to_no_perdeu", bus.perdeu, 1'b0);
    bus.timeout = 1'b0;
`endif

    // round 3: two good repeats then a wrong third play
    bus.enderecoIgualRodada = 1'b0; bus.igual = 1'b1;
    for (int k = 0; k < 2; k++) begin
      pulse_jogada(); tick(); tick();
      chk("r3_prox_jogada", db_estado, 4'h8);
      tick(); chk("r3_back_espera", db_estado, 4'h5);
    end
    bus.igual = 1'b0;
    pulse_jogada(); tick(); tick();
    chk("r3_perdeu", db_estado, 4'hD);
    tick();
    for (int k = 0; k < 100; k++) begin
      chk("r3_perdeu_hold", {bus.pronto, bus.ganhou, bus.perdeu}, 3'b101);
      tick();
    end
    bus.iniciar = 1'b1; tick(); bus.iniciar = 1'b0;
    chk("r3_restart", db_estado, 4'h1);

    // final round win
    to_espera_from_prepara();
    bus.igual = 1'b1; bus.enderecoIgualRodada = 1'b1; bus.fimRodadas = 1'b1;
    pulse_jogada(); tick(); tick();
    chk("win_state", db_estado, 4'hC);
    tick();
    chk("win_outputs", {bus.pronto, bus.ganhou, bus.perdeu}, 3'b110);
    bus.fimRodadas = 1'b0;

    // async reset in the middle of EXIBE
    bus.iniciar = 1'b1; tick(); bus.iniciar = 1'b0;
    tick(); tick(); tick();
    chk("mid_exibe", db_estado, 4'h3);
    @(negedge clock); #2;
    reset = 1'b0;
    #1;
    chk("async_state", db_estado, 4'h0);
    chk("async_outputs", act, 12'h000);
    tick(); reset = 1'b1;
    tick(); tick();
    chk("post_reset_idle", db_estado, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
